// File: rtl/hex_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scan_ctrl_if
//  Description : Register-side and display-side signal bundle for
//                hex_scan_ctrl. The master drives the write/enable side and
//                observes the display side. The slave is the scan controller.
//  Ports       : enable, load, wr_data[4*NDIGITS], wr_dp[NDIGITS]   (m -> s)
//                HEX[4], digit_n[NDIGITS], dp_n, frame_done          (s -> m)
//  Revision    : 1.0  initial release
// ============================================================================
interface hex_scan_ctrl_if #(
    parameter int NDIGITS = 4
);
    logic                   enable;
    logic                   load;
    logic [4*NDIGITS-1:0]   wr_data;
    logic [NDIGITS-1:0]     wr_dp;
    logic [3:0]             HEX;
    logic [NDIGITS-1:0]     digit_n;
    logic                   dp_n;
    logic                   frame_done;

    modport master (
        output enable, load, wr_data, wr_dp,
        input  HEX, digit_n, dp_n, frame_done
    );

    modport slave (
        input  enable, load, wr_data, wr_dp,
        output HEX, digit_n, dp_n, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scan_ctrl
//  Description : Time-multiplexes NDIGITS hex digits through one shared
//                hex2led decoder. Each digit slot is a blanking gap of
//                BLANK_CYCLES (all anodes off) followed by DRIVE_CYCLES with
//                that digit's anode low. Display data is double-buffered and
//                the active copy only changes at a frame boundary.
//  Ports       : clk      - system clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - hex_scan_ctrl_if.slave
//                           enable/load/wr_data/wr_dp in,
//                           HEX/digit_n/dp_n/frame_done out (all registered)
//  Options     : LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//                (except digit 0, and except digits whose dp bit is set)
//                keep their time slot but stay dark.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_scan_ctrl #(
    parameter int NDIGITS      = 4,
    parameter int DRIVE_CYCLES = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    hex_scan_ctrl_if.slave      bus
);

    localparam int c_MAXC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int c_CW   = $clog2(c_MAXC + 1);
    localparam int c_IW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [c_CW-1:0] c_DRIVE_LAST = c_CW'(DRIVE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // With no blanking gap every slot starts straight in DRIVE.
    localparam state_t c_SLOT_START = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;

    state_t                 state_q,      state_d;
    logic [c_IW-1:0]        idx_q,        idx_d;
    logic [c_CW-1:0]        cnt_q,        cnt_d;
    logic [4*NDIGITS-1:0]   active_q,     active_d;
    logic [NDIGITS-1:0]     active_dp_q,  active_dp_d;
    logic [4*NDIGITS-1:0]   shadow_q,     shadow_d;
    logic [NDIGITS-1:0]     shadow_dp_q,  shadow_dp_d;
    logic                   pending_q,    pending_d;
    logic [3:0]             hex_q,        hex_d;
    logic [NDIGITS-1:0]     digit_n_q,    digit_n_d;
    logic                   dp_n_q,       dp_n_d;
    logic                   frame_done_q, frame_done_d;

    logic                   w_frame_end;
    logic                   w_lit;
    logic [NDIGITS-1:0]     w_supp;

    // ------------------------------------------------------------------
    // Sequencing and double-buffer update
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        active_dp_d  = active_dp_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        w_frame_end  = 1'b0;

        if (!bus.enable) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = c_SLOT_START;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                S_BLANK: begin
                    if (cnt_q == c_BLANK_LAST) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + c_CW'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == c_DRIVE_LAST) begin
                        state_d = c_SLOT_START;
                        cnt_d   = '0;
                        if (idx_q == c_IDX_LAST) begin
                            idx_d       = '0;
                            w_frame_end = 1'b1;
                        end else begin
                            idx_d       = idx_q + c_IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + c_CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // A load landing on the last cycle of a frame bypasses the shadow so
        // the very next frame already shows it; otherwise the shadow waits.
        if (w_frame_end && bus.load) begin
            active_d    = bus.wr_data;
            active_dp_d = bus.wr_dp;
            shadow_d    = bus.wr_data;
            shadow_dp_d = bus.wr_dp;
            pending_d   = 1'b0;
        end else begin
            if (w_frame_end && pending_q) begin
                active_d    = shadow_q;
                active_dp_d = shadow_dp_q;
                pending_d   = 1'b0;
            end
            if (bus.load) begin
                shadow_d    = bus.wr_data;
                shadow_dp_d = bus.wr_dp;
                pending_d   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression mask, from next-cycle active data
    // ------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    for (genvar gk = 0; gk < NDIGITS; gk++) begin : g_lzb
        if (gk == 0) begin : g_digit0
            assign w_supp[gk] = 1'b0;
        end else begin : g_upper
            assign w_supp[gk] = ~active_dp_d[gk] &&
                                (active_d[4*NDIGITS-1:4*gk] == '0);
        end
    end
`else
    assign w_supp = '0;
`endif

    // ------------------------------------------------------------------
    // Output decode of the next state, so outputs are registered yet line
    // up with the state register in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_lit        = (state_d == S_DRIVE) && !w_supp[idx_d];
        hex_d        = (state_d == S_IDLE) ? 4'h0 : active_d[{idx_d, 2'b00} +: 4];
        digit_n_d    = '1;
        dp_n_d       = 1'b1;
        if (w_lit) begin
            digit_n_d[idx_d] = 1'b0;
            dp_n_d           = ~active_dp_d[idx_d];
        end
        frame_done_d = (state_d == S_DRIVE) && (idx_d == c_IDX_LAST) &&
                       (cnt_d == c_DRIVE_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            hex_q        <= 4'h0;
            digit_n_q    <= '1;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            hex_q        <= hex_d;
            digit_n_q    <= digit_n_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.HEX        = hex_q;
    assign bus.digit_n    = digit_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_scan_ctrl
//  Description : Self-checking bench for hex_scan_ctrl (4 digits, 4 drive,
//                2 blank clocks). Frame-position reference model plus
//                table-driven frame checks and directed corner sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hex_scan_ctrl;

    localparam int ND    = 4;
    localparam int DC    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = DC + BC;
    localparam int FRAME = ND * SLOT;

    logic clk;
    logic reset_n;

    hex_scan_ctrl_if #(.NDIGITS(ND)) bus ();

    hex_scan_ctrl #(
        .NDIGITS      (ND),
        .DRIVE_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Reference model: position within the frame counted from scan start
    // ------------------------------------------------------------------
    bit          m_run;
    int          m_t;
    logic [15:0] m_act, m_sh;
    logic [3:0]  m_adp, m_shdp;
    bit          m_pend;

    task automatic model_reset();
        m_run = 0; m_t = 0; m_act = '0; m_adp = '0;
        m_sh = '0; m_shdp = '0; m_pend = 0;
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    function automatic bit m_supp(input int d);
        if (d == 0)   return 0;
        if (m_adp[d]) return 0;
        for (int j = d; j < ND; j++)
            if (m_act[4*j +: 4] != 4'h0) return 0;
        return 1;
    endfunction
`endif

    task automatic model_edge(input logic en, input logic ld,
                              input logic [15:0] wd, input logic [3:0] wdp);
        if (!en || !m_run) begin
            m_run = en;
            m_t   = 0;
            if (ld) begin m_sh = wd; m_shdp = wdp; m_pend = 1; end
        end else begin
            if (m_t == FRAME - 1) begin
                if (ld) begin
                    m_act = wd; m_adp = wdp; m_sh = wd; m_shdp = wdp; m_pend = 0;
                end else if (m_pend) begin
                    m_act = m_sh; m_adp = m_shdp; m_pend = 0;
                end
            end else if (ld) begin
                m_sh = wd; m_shdp = wdp; m_pend = 1;
            end
            m_t = (m_t + 1) % FRAME;
        end
    endtask

    task automatic check_model();
        logic [3:0] e_hex, e_dn;
        logic       e_dp, e_fd, lit;
        int         d, w;
        if (!m_run) begin
            e_hex = 4'h0; e_dn = 4'hF; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            d     = m_t / SLOT;
            w     = m_t % SLOT;
            e_hex = m_act[4*d +: 4];
            lit   = (w >= BC)
`ifdef LEADING_ZERO_BLANK_EN
                    && !m_supp(d)
`endif
                    ;
            e_dn  = lit ? ~(4'b0001 << d) : 4'hF;
            e_dp  = lit ? ~m_adp[d] : 1'b1;
            e_fd  = (m_t == FRAME - 1);
        end
        n_tests++;
        if (bus.HEX !== e_hex || bus.digit_n !== e_dn ||
            bus.dp_n !== e_dp || bus.frame_done !== e_fd) begin
            n_fail++;
            $display("FAIL model @%0t: got HEX=%h dn=%b dp_n=%b fd=%b, want HEX=%h dn=%b dp_n=%b fd=%b",
                     $time, bus.HEX, bus.digit_n, bus.dp_n, bus.frame_done,
                     e_hex, e_dn, e_dp, e_fd);
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic ld,
                        input logic [15:0] wd, input logic [3:0] wdp);
        bus.enable  = en;
        bus.load    = ld;
        bus.wr_data = wd;
        bus.wr_dp   = wdp;
        @(posedge clk);
        model_edge(en, ld, wd, wdp);
        #1;
        check_model();
        bus.load = 1'b0;
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, 16'h0000, 4'h0);
    endtask

    task automatic run_until_fd();
        bit found = 0;
        for (int i = 0; i < 2 * FRAME + 4 && !found; i++) begin
            idle_step();
            if (bus.frame_done === 1'b1) found = 1;
        end
        chk("wait_frame_done", 16'(found), 16'h1);
    endtask

    task automatic run_until_dn(input logic [3:0] target);
        bit found = 0;
        for (int i = 0; i < 2 * FRAME + 4 && !found; i++) begin
            idle_step();
            if (bus.digit_n === target) found = 1;
        end
        chk("wait_digit_n", 16'(found), 16'h1);
    endtask

    // ------------------------------------------------------------------
    // Table of frame contents: expected per-digit HEX, lit anode pattern
    // and dp_n, each field ordered {digit3,digit2,digit1,digit0}.
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [15:0] hex;
        logic [15:0] dn;
        logic [3:0]  dpn;
    } vec_t;

    vec_t vt[6];

    // Walks frame slots first..FRAME-1, one clock each, against a table entry.
    task automatic check_frame(input vec_t v, input int first);
        int d, c;
        for (int s = first; s < FRAME; s++) begin
            idle_step();
            d = s / SLOT;
            c = s % SLOT;
            chk("frame_hex", 16'(bus.HEX), 16'(v.hex[4*d +: 4]));
            chk("frame_digit_n", 16'(bus.digit_n),
                (c < BC) ? 16'hF : 16'(v.dn[4*d +: 4]));
            if (c >= BC) chk("frame_dp_n", 16'(bus.dp_n), 16'(v.dpn[d]));
            chk("frame_done", 16'(bus.frame_done), 16'(s == FRAME - 1));
        end
    endtask

    initial begin
        vt[0] = '{data:16'h1A3F, dp:4'b0010, hex:16'h1A3F, dn:16'h7BDE, dpn:4'b1101};
`ifdef LEADING_ZERO_BLANK_EN
        vt[1] = '{data:16'h0042, dp:4'b0000, hex:16'h0042, dn:16'hFFDE, dpn:4'b1111};
        vt[3] = '{data:16'h0000, dp:4'b0000, hex:16'h0000, dn:16'hFFFE, dpn:4'b1111};
        vt[4] = '{data:16'h0000, dp:4'b1000, hex:16'h0000, dn:16'h7FFE, dpn:4'b0111};
        vt[5] = '{data:16'h0800, dp:4'b0001, hex:16'h0800, dn:16'hFBDE, dpn:4'b1110};
`else
        vt[1] = '{data:16'h0042, dp:4'b0000, hex:16'h0042, dn:16'h7BDE, dpn:4'b1111};
        vt[3] = '{data:16'h0000, dp:4'b0000, hex:16'h0000, dn:16'h7BDE, dpn:4'b1111};
        vt[4] = '{data:16'h0000, dp:4'b1000, hex:16'h0000, dn:16'h7BDE, dpn:4'b0111};
        vt[5] = '{data:16'h0800, dp:4'b0001, hex:16'h0800, dn:16'h7BDE, dpn:4'b1110};
`endif
        vt[2] = '{data:16'h5555, dp:4'b1111, hex:16'h5555, dn:16'h7BDE, dpn:4'b0000};

        // Reset values
        reset_n     = 1'b0;
        bus.enable  = 1'b0;
        bus.load    = 1'b0;
        bus.wr_data = '0;
        bus.wr_dp   = '0;
        model_reset();
        #12;
        chk("reset_HEX", 16'(bus.HEX), 16'h0);
        chk("reset_digit_n", 16'(bus.digit_n), 16'hF);
        chk("reset_dp_n", 16'(bus.dp_n), 16'h1);
        chk("reset_frame_done", 16'(bus.frame_done), 16'h0);
        reset_n = 1'b1;
        step(1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b0, 16'h0, 4'h0);

        // 1A3F: loaded at scan start, visible from the first swap onwards
        step(1'b1, 1'b1, 16'h1A3F, 4'b0010);
        run_until_fd();
        check_frame(vt[0], 0);
        check_frame(vt[0], 0);

        // Table patterns, each loaded mid-frame
        for (int i = 1; i < 6; i++) begin
            idle_step(); idle_step(); idle_step();
            step(1'b1, 1'b1, vt[i].data, vt[i].dp);
            run_until_fd();
            check_frame(vt[i], 0);
        end

        // Mid-frame load while digit 1 is lit: rest of frame keeps old data
        idle_step(); idle_step();
        step(1'b1, 1'b1, vt[0].data, vt[0].dp);
        run_until_fd();
        run_until_dn(4'b1101);
        step(1'b1, 1'b1, 16'h0042, 4'b0000);
        run_until_dn(4'b1011);
        chk("midload_old_digit2", 16'(bus.HEX), 16'hA);
        run_until_dn(4'b0111);
        chk("midload_old_digit3", 16'(bus.HEX), 16'h1);
        run_until_fd();
        check_frame(vt[1], 0);

        // Load on the frame_done cycle goes straight to the next frame
        step(1'b1, 1'b1, 16'h5555, 4'b1111);
        chk("fdload_hex_slot0", 16'(bus.HEX), 16'h5);
        chk("fdload_pending", 16'(dut.pending_q), 16'h0);
        check_frame(vt[2], 1);

        // Drop enable during digit 2 DRIVE, then restart at digit 0 BLANK
        run_until_dn(4'b1011);
        step(1'b0, 1'b0, 16'h0, 4'h0);
        chk("disable_digit_n", 16'(bus.digit_n), 16'hF);
        idle_step();
        chk("reenable_blank0", 16'(bus.digit_n), 16'hF);
        chk("reenable_hex0", 16'(bus.HEX), 16'h5);
        idle_step();
        chk("reenable_blank1", 16'(bus.digit_n), 16'hF);
        idle_step();
        chk("reenable_drive0", 16'(bus.digit_n), 16'hE);

        // Asynchronous reset in the middle of a BLANK phase
        run_until_fd();
        idle_step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_HEX", 16'(bus.HEX), 16'h0);
        chk("areset_digit_n", 16'(bus.digit_n), 16'hF);
        chk("areset_dp_n", 16'(bus.dp_n), 16'h1);
        chk("areset_frame_done", 16'(bus.frame_done), 16'h0);
        model_reset();
        #2;
        reset_n = 1'b1;
        run_until_fd();
        check_frame(vt[3], 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic        en, ld;
            logic [15:0] wd;
            logic [3:0]  wdp;
            en  = ($urandom % 40) != 0;
            ld  = ($urandom % 10) == 0;
            wd  = 16'($urandom);
            if ($urandom % 2) wd = wd >> (4 * ($urandom % 4));
            wdp = 4'($urandom);
            if ($urandom % 2) wdp = 4'h0;
            step(en, ld, wd, wdp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
